// File: rtl/cpu_mem_seq_pkg.sv
// Shared definitions for the data-memory access sequencer.
// Holds data/address widths, memory-op encodings, FSM state enum, op helpers.
// CPU_MEM_BIT_EN: when defined, bit ops (BSET/BCLR/BCPL) are read-modify-write.
// When it is undefined, they degrade to plain reads.
package cpu_mem_seq_pkg;

    localparam int CPU_DATA_WIDTH = 8;
    localparam int CPU_ADDR_WIDTH = 8;

    localparam logic [2:0] MOP_READ  = 3'd0;
    localparam logic [2:0] MOP_WRITE = 3'd1;
    localparam logic [2:0] MOP_ANL   = 3'd2;
    localparam logic [2:0] MOP_ORL   = 3'd3;
    localparam logic [2:0] MOP_XRL   = 3'd4;
    localparam logic [2:0] MOP_BSET  = 3'd5;
    localparam logic [2:0] MOP_BCLR  = 3'd6;
    localparam logic [2:0] MOP_BCPL  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } mem_state_t;

    // True for ops that write back after the read phase.
    function automatic logic mop_is_rmw(input logic [2:0] op);
`ifdef CPU_MEM_BIT_EN
        return (op >= MOP_ANL);
`else
        return (op == MOP_ANL) || (op == MOP_ORL) || (op == MOP_XRL);
`endif
    endfunction

endpackage

// File: rtl/cpu_mem_alu.sv
// Combinational modify stage for read-modify-write ops: logic and bit ops.
// Ports: i_op, i_byte (value read), i_operand, i_bit -> o_result.
// Macro CPU_MEM_BIT_EN: enables the bit-mask ops; otherwise they return i_byte.
module cpu_mem_alu
    import cpu_mem_seq_pkg::*;
(
    input  logic [2:0]                i_op,
    input  logic [CPU_DATA_WIDTH-1:0] i_byte,
    input  logic [CPU_DATA_WIDTH-1:0] i_operand,
    input  logic [2:0]                i_bit,
    output logic [CPU_DATA_WIDTH-1:0] o_result
);

`ifdef CPU_MEM_BIT_EN
    logic [CPU_DATA_WIDTH-1:0] w_mask;
    assign w_mask = CPU_DATA_WIDTH'(1) << i_bit;
`else
    logic w_unused_bit;
    assign w_unused_bit = ^i_bit;
`endif

    always_comb begin
        // READ/WRITE (and bit ops when disabled) pass the byte through.
        o_result = i_byte;
        case (i_op)
            MOP_ANL:  o_result = i_byte & i_operand;
            MOP_ORL:  o_result = i_byte | i_operand;
            MOP_XRL:  o_result = i_byte ^ i_operand;
`ifdef CPU_MEM_BIT_EN
            MOP_BSET: o_result = i_byte | w_mask;
            MOP_BCLR: o_result = i_byte & ~w_mask;
            MOP_BCPL: o_result = i_byte ^ w_mask;
`endif
            default:  o_result = i_byte;
        endcase
    end

endmodule

// File: rtl/cpu_mem_seq.sv
// Data-memory sequencer: one request at a time onto the RAM/SFR bus, atomic RMW.
// Ports: REQ_* request (valid/ready), RSP_* single-cycle response pulse, MEM_* bus.
// Latency: WRITE 1 cycle, READ/RMW 3 cycles after accept; no response backpressure.
// Macro CPU_MEM_BIT_EN (via cpu_mem_alu / package): bit ops as RMW, else as READ.
module cpu_mem_seq
    import cpu_mem_seq_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic [2:0]                REQ_OP,
    input  logic [CPU_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [CPU_DATA_WIDTH-1:0] REQ_DATA,
    input  logic [2:0]                REQ_BIT,
    output logic                      RSP_VALID,
    output logic [CPU_DATA_WIDTH-1:0] RSP_DATA,
    output logic [CPU_ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [CPU_DATA_WIDTH-1:0] MEM_WR_DATA,
    output logic                      MEM_RD,
    output logic                      MEM_WR,
    input  logic [CPU_DATA_WIDTH-1:0] MEM_RD_DATA
);

    mem_state_t                r_state;
    mem_state_t                w_next;
    logic [2:0]                r_op;
    logic [CPU_ADDR_WIDTH-1:0] r_addr;
    logic [CPU_DATA_WIDTH-1:0] r_operand;
    logic [2:0]                r_bit;
    // Single data register: write data on accept, then read byte / RMW result.
    logic [CPU_DATA_WIDTH-1:0] r_data;
    logic [CPU_DATA_WIDTH-1:0] w_alu_result;
    logic                      w_accept;

    assign w_accept = REQ_VALID && REQ_READY;

    cpu_mem_alu u_alu (
        .i_op      (r_op),
        .i_byte    (MEM_RD_DATA),
        .i_operand (r_operand),
        .i_bit     (r_bit),
        .o_result  (w_alu_result)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_op      <= MOP_READ;
            r_addr    <= '0;
            r_operand <= '0;
            r_bit     <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op      <= REQ_OP;
                r_addr    <= REQ_ADDR;
                r_operand <= REQ_DATA;
                r_bit     <= REQ_BIT;
                r_data    <= REQ_DATA;
            end else if (r_state == ST_CAP) begin
                r_data <= w_alu_result;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        REQ_READY   = 1'b0;
        MEM_RD      = 1'b0;
        MEM_WR      = 1'b0;
        RSP_VALID   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                REQ_READY = 1'b1;
                if (w_accept) w_next = (REQ_OP == MOP_WRITE) ? ST_WR : ST_RD;
            end
            ST_RD: begin
                MEM_RD = 1'b1;
                w_next = ST_CAP;
            end
            ST_CAP: begin
                w_next = mop_is_rmw(r_op) ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                MEM_WR    = 1'b1;
                RSP_VALID = 1'b1;
                w_next    = ST_IDLE;
            end
            ST_DONE: begin
                RSP_VALID = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Reset suppresses every strobe in the same cycle, so an in-flight
        // request can never write or respond once reset is seen.
        if (RST) begin
            REQ_READY = 1'b0;
            MEM_RD    = 1'b0;
            MEM_WR    = 1'b0;
            RSP_VALID = 1'b0;
        end
    end

    // Address holds its last value in IDLE since r_addr only loads on accept.
    assign MEM_ADDR    = r_addr;
    assign MEM_WR_DATA = r_data;
    assign RSP_DATA    = r_data;

endmodule
